// File: rtl/key_player.sv
// Keypad stimulus generator: replays a latched 32-bit combination as timed
// one-hot key presses, optionally preceded by the arming key 16.
module key_player #(
    parameter int HOLD_CYC = 4,
    parameter int GAP_CYC  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        lead_en,
    input  logic [31:0] seq,
    output logic [19:0] pb_out,
    output logic        busy,
    output logic        done,
    output logic [3:0]  key_idx
);

    localparam int MAXC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYC - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRESS   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;
    localparam logic [1:0] S_FINISH  = 2'd3;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_key_idx;
    logic [31:0]   r_seq;
    logic          r_lead;
    logic [19:0]   r_pb;
    logic          r_busy;
    logic          r_done;

    logic          w_idle;
    logic          w_lead;
    logic [31:0]   w_seq;
    logic [3:0]    w_nidx;
    logic [2:0]    w_dpos;
    logic [3:0]    w_nib;
    logic [19:0]   w_key_oh;
    logic          w_last;
    logic          w_cnt_zero;

    // Key to drive on the next PRESS entry: from the live inputs when
    // starting, otherwise from the latched copy at the following index.
    always_comb begin
        w_idle   = (r_state == S_IDLE);
        w_lead   = w_idle ? lead_en : r_lead;
        w_seq    = w_idle ? seq : r_seq;
        w_nidx   = w_idle ? 4'd0 : r_key_idx + 4'd1;
        w_dpos   = w_lead ? 3'(w_nidx - 4'd1) : 3'(w_nidx);
        w_nib    = 4'(w_seq >> (5'd28 - {w_dpos, 2'b00}));
        w_key_oh = 20'd0;
        if (w_lead && (w_nidx == 4'd0)) begin
            w_key_oh = 20'h1_0000;
        end else begin
            w_key_oh = 20'd1 << w_nib;
        end
        w_last     = (r_key_idx == (r_lead ? 4'd8 : 4'd7));
        w_cnt_zero = (r_cnt == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_key_idx <= 4'd0;
            r_seq     <= 32'd0;
            r_lead    <= 1'b0;
            r_pb      <= 20'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_state   <= S_PRESS;
                        r_seq     <= seq;
                        r_lead    <= lead_en;
                        r_key_idx <= 4'd0;
                        r_cnt     <= HOLD_LD;
                        r_pb      <= w_key_oh;
                        r_busy    <= 1'b1;
                    end
                end
                S_PRESS: begin
                    if (abort) begin
                        r_state   <= S_IDLE;
                        r_pb      <= 20'd0;
                        r_busy    <= 1'b0;
                        r_key_idx <= 4'd0;
                    end else if (w_cnt_zero) begin
                        r_state <= S_RELEASE;
                        r_cnt   <= GAP_LD;
                        r_pb    <= 20'd0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (abort) begin
                        r_state   <= S_IDLE;
                        r_pb      <= 20'd0;
                        r_busy    <= 1'b0;
                        r_key_idx <= 4'd0;
                    end else if (w_cnt_zero) begin
                        if (w_last) begin
                            r_state <= S_FINISH;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= S_PRESS;
                            r_key_idx <= w_nidx;
                            r_cnt     <= HOLD_LD;
                            r_pb      <= w_key_oh;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_key_idx <= 4'd0;
                end
            endcase
        end
    end

    assign pb_out  = r_pb;
    assign busy    = r_busy;
    assign done    = r_done;
    assign key_idx = r_key_idx;

endmodule

// File: tb/tb_key_player.sv
// Scoreboard bench for key_player: expected per-cycle outputs are queued
// at start and popped one per cycle while the DUT plays.
module tb_key_player;

    typedef struct {
        logic [19:0] pb;
        logic        busy;
        logic        done;
        logic [3:0]  kidx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        abort = 1'b0;
    logic        lead_i = 1'b0;
    logic [31:0] seq_i = 32'd0;

    logic [19:0] pb_a, pb_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic [3:0]  kidx_a, kidx_b;

    int checks = 0;
    int passed = 0;
    exp_t q[$];
    exp_t e;

    always #5 clk = ~clk;

    key_player #(.HOLD_CYC(4), .GAP_CYC(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort),
        .lead_en(lead_i), .seq(seq_i), .pb_out(pb_a),
        .busy(busy_a), .done(done_a), .key_idx(kidx_a)
    );

    key_player #(.HOLD_CYC(3), .GAP_CYC(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort),
        .lead_en(lead_i), .seq(seq_i), .pb_out(pb_b),
        .busy(busy_b), .done(done_b), .key_idx(kidx_b)
    );

    task automatic push_exp(input logic [31:0] s, input logic ld,
                            input int hold, input int gap);
        int n;
        int key;
        exp_t x;
        n = ld ? 9 : 8;
        for (int k = 0; k < n; k++) begin
            if (ld && k == 0) key = 16;
            else key = int'((s >> (28 - 4 * (ld ? k - 1 : k))) & 32'hF);
            for (int c = 0; c < hold; c++) begin
                x.pb = 20'd1 << key; x.busy = 1'b1;
                x.done = 1'b0; x.kidx = 4'(k);
                q.push_back(x);
            end
            for (int c = 0; c < gap; c++) begin
                x.pb = 20'd0; x.busy = 1'b1;
                x.done = 1'b0; x.kidx = 4'(k);
                q.push_back(x);
            end
        end
        x.pb = 20'd0; x.busy = 1'b0; x.done = 1'b1; x.kidx = 4'd0;
        q.push_back(x);
    endtask

    task automatic do_start(input logic [31:0] s, input logic ld,
                            input logic use_b);
        @(negedge clk);
        seq_i = s; lead_i = ld;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0; start_b = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({pb_a, busy_a, done_a, kidx_a} !== 26'd0)
            $display("FAIL reset_init got %h/%b/%b/%h exp 0",
                     pb_a, busy_a, done_a, kidx_a);
        else passed++;
        @(negedge clk); rst = 1'b1;
        do_start(32'h1234ABCD, 1'b1, 1'b0);
        @(negedge clk); @(negedge clk);
        checks++;
        if (pb_a !== 20'h1_0000) $display("FAIL reset_pre got %h exp 10000", pb_a);
        else passed++;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (pb_a !== 20'd0 || busy_a !== 1'b0)
            $display("FAIL reset_async got %h/%b exp 0/0", pb_a, busy_a);
        else passed++;
        @(negedge clk); rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            checks++;
            if (pb_a !== 20'd0 || busy_a !== 1'b0 || done_a !== 1'b0)
                $display("FAIL reset_idle got %h/%b/%b exp 0/0/0", pb_a, busy_a, done_a);
            else passed++;
        end
    endtask

    task automatic test_lead;
        int cyc = 0;
        q.delete();
        push_exp(32'h1234ABCD, 1'b1, 4, 4);
        do_start(32'h1234ABCD, 1'b1, 1'b0);
        while (q.size() > 0) begin
            @(negedge clk);
            cyc++;
            e = q.pop_front();
            checks++;
            if (pb_a !== e.pb || busy_a !== e.busy || done_a !== e.done ||
                (e.busy && kidx_a !== e.kidx))
                $display("FAIL lead c%0d got %h/%b/%b/%0d exp %h/%b/%b/%0d",
                         cyc, pb_a, busy_a, done_a, kidx_a, e.pb, e.busy, e.done, e.kidx);
            else passed++;
        end
        checks++;
        if (cyc != 73) $display("FAIL lead_len got %0d exp 73", cyc);
        else passed++;
    endtask

    task automatic test_back_to_back_nolead;
        int cyc = 0;
        int nbusy = 0;
        q.delete();
        push_exp(32'h00000000, 1'b0, 4, 4);
        do_start(32'h00000000, 1'b0, 1'b0);
        while (q.size() > 0) begin
            @(negedge clk);
            cyc++;
            e = q.pop_front();
            if (busy_a === 1'b1) nbusy++;
            checks++;
            if (pb_a !== e.pb || busy_a !== e.busy || done_a !== e.done ||
                (e.busy && kidx_a !== e.kidx))
                $display("FAIL nolead c%0d got %h/%b/%b/%0d exp %h/%b/%b/%0d",
                         cyc, pb_a, busy_a, done_a, kidx_a, e.pb, e.busy, e.done, e.kidx);
            else passed++;
        end
        checks++;
        if (nbusy != 64) $display("FAIL nolead_busy got %0d exp 64", nbusy);
        else passed++;
    endtask

    task automatic test_abort;
        int dn = 0;
        int act = 0;
        q.delete();
        push_exp(32'h76543210, 1'b0, 4, 4);
        do_start(32'h76543210, 1'b0, 1'b0);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (pb_a !== e.pb || busy_a !== e.busy || kidx_a !== e.kidx)
                $display("FAIL abort_pre c%0d got %h/%b/%0d exp %h/%b/%0d",
                         c, pb_a, busy_a, kidx_a, e.pb, e.busy, e.kidx);
            else passed++;
        end
        q.delete();
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        checks++;
        if (pb_a !== 20'd0 || busy_a !== 1'b0 || kidx_a !== 4'd0 || done_a !== 1'b0)
            $display("FAIL abort_next got %h/%b/%0d/%b exp 0/0/0/0",
                     pb_a, busy_a, kidx_a, done_a);
        else passed++;
        repeat (80) begin
            @(negedge clk);
            if (done_a === 1'b1) dn++;
            if (pb_a !== 20'd0 || busy_a !== 1'b0) act++;
        end
        checks++;
        if (dn != 0 || act != 0)
            $display("FAIL abort_quiet got done=%0d act=%0d exp 0/0", dn, act);
        else passed++;
    endtask

    task automatic test_start_abort;
        int act = 0;
        @(negedge clk);
        seq_i = 32'h11111111; lead_i = 1'b1;
        start_a = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0; abort = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (pb_a !== 20'd0 || busy_a !== 1'b0 || done_a !== 1'b0) act++;
        end
        checks++;
        if (act != 0) $display("FAIL start_abort got %0d active cycles exp 0", act);
        else passed++;
    endtask

    task automatic test_start_busy;
        int cyc = 0;
        q.delete();
        push_exp(32'h0F1E2D3C, 1'b1, 4, 4);
        do_start(32'h0F1E2D3C, 1'b1, 1'b0);
        while (q.size() > 0) begin
            @(negedge clk);
            cyc++;
            start_a = 1'b0;
            e = q.pop_front();
            checks++;
            if (pb_a !== e.pb || busy_a !== e.busy || done_a !== e.done ||
                (e.busy && kidx_a !== e.kidx))
                $display("FAIL start_busy c%0d got %h/%b/%b/%0d exp %h/%b/%b/%0d",
                         cyc, pb_a, busy_a, done_a, kidx_a, e.pb, e.busy, e.done, e.kidx);
            else passed++;
            if (cyc == 5 || cyc == 40) begin
                start_a = 1'b1; seq_i = 32'hFFFFFFFF; lead_i = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b0 || pb_a !== 20'd0)
            $display("FAIL start_busy_end got %b/%h exp 0/0", busy_a, pb_a);
        else passed++;
    endtask

    task automatic test_sweep;
        int cyc = 0;
        q.delete();
        push_exp(32'hF0E1D2C3, 1'b1, 3, 3);
        do_start(32'hF0E1D2C3, 1'b1, 1'b1);
        while (q.size() > 0) begin
            @(negedge clk);
            cyc++;
            e = q.pop_front();
            checks++;
            if (pb_b !== e.pb || busy_b !== e.busy || done_b !== e.done ||
                (e.busy && kidx_b !== e.kidx) || !$onehot0(pb_b))
                $display("FAIL sweep c%0d got %h/%b/%b/%0d exp %h/%b/%b/%0d",
                         cyc, pb_b, busy_b, done_b, kidx_b, e.pb, e.busy, e.done, e.kidx);
            else passed++;
        end
        checks++;
        if (cyc != 55) $display("FAIL sweep_len got %0d exp 55", cyc);
        else passed++;
    endtask

    initial begin
        test_reset;
        test_lead;
        test_back_to_back_nolead;
        test_abort;
        test_start_abort;
        test_start_busy;
        test_sweep;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout passed=%0d checks=%0d", passed, checks);
        $fatal(1, "timeout");
    end

endmodule
